// File: rtl/frame_config_pkg.sv
// Shared types and header layout for the configuration frame writer.
// The header field positions assume a 32-bit bitstream word.
package frame_config_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HEADER = 2'd1,
        ST_DATA   = 2'd2,
        ST_STROBE = 2'd3
    } state_e;

    localparam int HDR_DESYNC_BIT = 31;
    localparam int HDR_COL_LSB    = 26;
    localparam int HDR_COL_W      = 5;
    localparam int HDR_FRAME_LSB  = 21;
    localparam int HDR_FRAME_W    = 5;

    localparam logic [31:0] SYNC_WORD_DEFAULT = 32'hFAB0_FAB1;

endpackage

// File: rtl/frame_config_writer_strobe.sv
// Registered one-hot decoder from (column, frame, fire) onto the FrameStrobe lines.
// Out-of-range addresses simply decode to all zeros.
module frame_strobe_decode
    import frame_config_pkg::*;
#(
    parameter int MaxFramesPerCol = 20,
    parameter int NumberOfCols    = 16
) (
    input  logic                                CLK,
    input  logic                                RST,
    input  logic [HDR_COL_W-1:0]                col,
    input  logic [HDR_FRAME_W-1:0]              frame,
    input  logic                                fire,
    output logic [NumberOfCols*MaxFramesPerCol-1:0] strobe
);

    logic [NumberOfCols*MaxFramesPerCol-1:0] strobe_d, strobe_q;

    always_comb begin
        strobe_d = '0;
        for (int c = 0; c < NumberOfCols; c++) begin
            for (int f = 0; f < MaxFramesPerCol; f++) begin
                strobe_d[c*MaxFramesPerCol+f] = fire && (col == HDR_COL_W'(c))
                                                && (frame == HDR_FRAME_W'(f));
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            strobe_q <= '0;
        end else begin
            strobe_q <= strobe_d;
        end
    end

    assign strobe = strobe_q;

endmodule

// File: rtl/frame_config_writer.sv
// Bitstream-driven configuration frame writer: hunts for the sync word, parses
// frame headers, fills the per-row FrameData registers and pulses FrameStrobe.
module frame_config_writer
    import frame_config_pkg::*;
#(
    parameter int          FrameBitsPerRow = 32,
    parameter int          MaxFramesPerCol = 20,
    parameter int          NumberOfRows    = 16,
    parameter int          NumberOfCols    = 16,
    parameter logic [31:0] SyncWord        = SYNC_WORD_DEFAULT
) (
    input  logic                                    CLK,
    input  logic                                    RST,
    input  logic [FrameBitsPerRow-1:0]              in_data,
    input  logic                                    in_valid,
    output logic                                    in_ready,
    output logic [NumberOfRows*FrameBitsPerRow-1:0] FrameData,
    output logic [NumberOfCols*MaxFramesPerCol-1:0] FrameStrobe,
    output logic                                    cfg_active,
    output logic                                    addr_err,
    output logic [15:0]                             frame_count
);

    localparam int ROW_W = (NumberOfRows > 1) ? $clog2(NumberOfRows) : 1;
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(NumberOfRows - 1);

    state_e                     state_q, state_d;
    logic [ROW_W-1:0]           row_q, row_d;
    logic [HDR_COL_W-1:0]       col_q, col_d;
    logic [HDR_FRAME_W-1:0]     frame_q, frame_d;
    logic                       discard_q, discard_d;
    logic                       cfg_active_q, cfg_active_d;
    logic                       addr_err_q, addr_err_d;
    logic [15:0]                frame_count_q, frame_count_d;
    logic [FrameBitsPerRow-1:0] data_q [NumberOfRows];
    logic [FrameBitsPerRow-1:0] data_d [NumberOfRows];

    logic                   accept;
    logic                   fire;
    logic                   is_sync;
    logic [HDR_COL_W-1:0]   hdr_col;
    logic [HDR_FRAME_W-1:0] hdr_frame;
    logic                   hdr_oor;

    // in_ready depends on the state register only, never on in_valid.
    assign in_ready  = (state_q != ST_STROBE);
    assign accept    = in_valid && in_ready;
    assign is_sync   = (in_data == SyncWord);
    assign hdr_col   = in_data[HDR_COL_LSB +: HDR_COL_W];
    assign hdr_frame = in_data[HDR_FRAME_LSB +: HDR_FRAME_W];
    assign hdr_oor   = (32'(hdr_col) >= NumberOfCols) || (32'(hdr_frame) >= MaxFramesPerCol);

    always_comb begin
        state_d       = state_q;
        row_d         = row_q;
        col_d         = col_q;
        frame_d       = frame_q;
        discard_d     = discard_q;
        addr_err_d    = addr_err_q;
        frame_count_d = frame_count_q;
        data_d        = data_q;
        fire          = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (accept && is_sync) state_d = ST_HEADER;
            end
            ST_HEADER: begin
                if (accept && !is_sync) begin
                    if (in_data[HDR_DESYNC_BIT]) begin
                        state_d = ST_IDLE;
                    end else begin
                        col_d     = hdr_col;
                        frame_d   = hdr_frame;
                        row_d     = '0;
                        discard_d = hdr_oor;
                        if (hdr_oor) addr_err_d = 1'b1;
                        state_d   = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (accept) begin
                    data_d[row_q] = in_data;
                    if (row_q == LAST_ROW) begin
                        // Discarded frames are consumed in full but never strobed.
                        if (discard_q) begin
                            state_d = ST_HEADER;
                        end else begin
                            state_d = ST_STROBE;
                            fire    = 1'b1;
                        end
                    end else begin
                        row_d = row_q + 1'b1;
                    end
                end
            end
            ST_STROBE: begin
                state_d = ST_HEADER;
                if (frame_count_q != 16'hFFFF) frame_count_d = frame_count_q + 16'd1;
            end
            default: state_d = ST_IDLE;
        endcase

        cfg_active_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q       <= ST_IDLE;
            row_q         <= '0;
            col_q         <= '0;
            frame_q       <= '0;
            discard_q     <= 1'b0;
            cfg_active_q  <= 1'b0;
            addr_err_q    <= 1'b0;
            frame_count_q <= '0;
            for (int r = 0; r < NumberOfRows; r++) data_q[r] <= '0;
        end else begin
            state_q       <= state_d;
            row_q         <= row_d;
            col_q         <= col_d;
            frame_q       <= frame_d;
            discard_q     <= discard_d;
            cfg_active_q  <= cfg_active_d;
            addr_err_q    <= addr_err_d;
            frame_count_q <= frame_count_d;
            data_q        <= data_d;
        end
    end

    frame_strobe_decode #(
        .MaxFramesPerCol (MaxFramesPerCol),
        .NumberOfCols    (NumberOfCols)
    ) u_strobe (
        .CLK    (CLK),
        .RST    (RST),
        .col    (col_q),
        .frame  (frame_q),
        .fire   (fire),
        .strobe (FrameStrobe)
    );

    for (genvar r = 0; r < NumberOfRows; r++) begin : g_rows
        assign FrameData[r*FrameBitsPerRow +: FrameBitsPerRow] = data_q[r];
    end

    assign cfg_active  = cfg_active_q;
    assign addr_err    = addr_err_q;
    assign frame_count = frame_count_q;

endmodule

// File: tb/tb_frame_config_writer.sv
// Directed bench for frame_config_writer: sync hunting, frame load/strobe,
// out-of-range headers, stalls, desync and mid-frame reset.
module tb_frame_config_writer;

    localparam int W  = 32;
    localparam int NR = 16;
    localparam int NC = 16;
    localparam int MF = 20;

    logic             CLK = 1'b0;
    logic             RST = 1'b1;
    logic [W-1:0]     in_data = '0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [NR*W-1:0]  FrameData;
    logic [NC*MF-1:0] FrameStrobe;
    logic             cfg_active;
    logic             addr_err;
    logic [15:0]      frame_count;

    int errors = 0;
    int checks = 0;
    logic [NC*MF-1:0] exp_s;

    frame_config_writer dut (
        .CLK         (CLK),
        .RST         (RST),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .FrameData   (FrameData),
        .FrameStrobe (FrameStrobe),
        .cfg_active  (cfg_active),
        .addr_err    (addr_err),
        .frame_count (frame_count)
    );

    always #5 CLK = ~CLK;

    // Presents one word and returns 1 time unit after the edge that accepted it.
    task automatic send(input logic [W-1:0] w);
        int n = 0;
        in_data  = w;
        in_valid = 1'b1;
        while (!in_ready && n < 50) begin
            @(posedge CLK); #1;
            n++;
        end
        if (n >= 50) begin
            errors++;
            $display("FAIL send_timeout: in_ready=%0b required 1", in_ready);
        end
        @(posedge CLK); #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge CLK); #1;
        end
    endtask

    function automatic logic [W-1:0] hdr(input int col, input int frm);
        logic [W-1:0] h = '0;
        h[30:26] = col[4:0];
        h[25:21] = frm[4:0];
        return h;
    endfunction

    task automatic test_reset();
        idle(2);
        @(negedge CLK);
        RST = 1'b0;
        @(posedge CLK); #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready: got %0b want 1", in_ready); end
        checks++; if (FrameData !== '0) begin errors++; $display("FAIL rst_framedata: got %0h want 0", FrameData); end
        checks++; if (FrameStrobe !== '0) begin errors++; $display("FAIL rst_strobe: got %0h want 0", FrameStrobe); end
        checks++; if (cfg_active !== 1'b0) begin errors++; $display("FAIL rst_cfg_active: got %0b want 0", cfg_active); end
        checks++; if (addr_err !== 1'b0) begin errors++; $display("FAIL rst_addr_err: got %0b want 0", addr_err); end
        checks++; if (frame_count !== 16'd0) begin errors++; $display("FAIL rst_frame_count: got %0d want 0", frame_count); end
    endtask

    task automatic test_garbage_then_sync();
        send(32'hFAB0_FAB0);
        checks++; if (cfg_active !== 1'b0) begin errors++; $display("FAIL garbage1_cfg: got %0b want 0", cfg_active); end
        send(32'hDEAD_BEEF);
        checks++; if (cfg_active !== 1'b0) begin errors++; $display("FAIL garbage2_cfg: got %0b want 0", cfg_active); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL garbage_ready: got %0b want 1", in_ready); end
        send(32'hFAB0_FAB1);
        checks++; if (cfg_active !== 1'b1) begin errors++; $display("FAIL sync_cfg: got %0b want 1", cfg_active); end
    endtask

    task automatic test_basic_frame();
        send(hdr(2, 5));
        for (int k = 0; k < NR; k++) begin
            send(32'h100 + k);
            if (k < NR - 1) begin
                checks++; if (FrameStrobe !== '0) begin errors++; $display("FAIL basic_early_strobe row %0d: got %0h want 0", k, FrameStrobe); end
            end
        end
        exp_s = '0; exp_s[2*MF+5] = 1'b1;
        checks++; if (FrameStrobe !== exp_s) begin errors++; $display("FAIL basic_strobe: got %0h want %0h", FrameStrobe, exp_s); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL basic_strobe_ready: got %0b want 0", in_ready); end
        for (int r = 0; r < NR; r++) begin
            checks++;
            if (FrameData[r*W +: W] !== 32'h100 + r) begin
                errors++; $display("FAIL basic_row %0d: got %0h want %0h", r, FrameData[r*W +: W], 32'h100 + r);
            end
        end
        idle(1);
        checks++; if (FrameStrobe !== '0) begin errors++; $display("FAIL basic_strobe_width: got %0h want 0", FrameStrobe); end
        checks++; if (frame_count !== 16'd1) begin errors++; $display("FAIL basic_count: got %0d want 1", frame_count); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL basic_ready_after: got %0b want 1", in_ready); end
    endtask

    task automatic test_addr_err();
        send(hdr(17, 0));
        checks++; if (addr_err !== 1'b1) begin errors++; $display("FAIL oor_addr_err: got %0b want 1", addr_err); end
        for (int k = 0; k < NR; k++) begin
            send(32'h200 + k);
            checks++; if (FrameStrobe !== '0) begin errors++; $display("FAIL oor_strobe row %0d: got %0h want 0", k, FrameStrobe); end
        end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL oor_ready: got %0b want 1", in_ready); end
        checks++; if (FrameData[5*W +: W] !== 32'h205) begin errors++; $display("FAIL oor_row5: got %0h want 205", FrameData[5*W +: W]); end
        idle(1);
        checks++; if (frame_count !== 16'd1) begin errors++; $display("FAIL oor_count: got %0d want 1", frame_count); end
        // Top corner of the address space: last column, last frame.
        send(hdr(15, 19));
        for (int k = 0; k < NR; k++) send(32'hA000 + k);
        exp_s = '0; exp_s[15*MF+19] = 1'b1;
        checks++; if (FrameStrobe !== exp_s) begin errors++; $display("FAIL corner_strobe: got %0h want %0h", FrameStrobe, exp_s); end
        idle(1);
        checks++; if (frame_count !== 16'd2) begin errors++; $display("FAIL corner_count: got %0d want 2", frame_count); end
        checks++; if (addr_err !== 1'b1) begin errors++; $display("FAIL addr_err_sticky: got %0b want 1", addr_err); end
    endtask

    task automatic test_gaps();
        send(hdr(0, 0));
        for (int k = 0; k < NR; k++) begin
            send(32'h300 + k);
            if (k < NR - 1) begin
                for (int g = 0; g < (k % 3); g++) begin
                    idle(1);
                    checks++; if (FrameStrobe !== '0) begin errors++; $display("FAIL gap_strobe row %0d: got %0h want 0", k, FrameStrobe); end
                end
            end
        end
        exp_s = '0; exp_s[0] = 1'b1;
        checks++; if (FrameStrobe !== exp_s) begin errors++; $display("FAIL gap_strobe_final: got %0h want %0h", FrameStrobe, exp_s); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL gap_ready: got %0b want 0", in_ready); end
        for (int r = 0; r < NR; r++) begin
            checks++;
            if (FrameData[r*W +: W] !== 32'h300 + r) begin
                errors++; $display("FAIL gap_row %0d: got %0h want %0h", r, FrameData[r*W +: W], 32'h300 + r);
            end
        end
        idle(1);
        checks++; if (frame_count !== 16'd3) begin errors++; $display("FAIL gap_count: got %0d want 3", frame_count); end
    endtask

    task automatic test_desync();
        send(32'h8000_0000);
        checks++; if (cfg_active !== 1'b0) begin errors++; $display("FAIL desync_cfg: got %0b want 0", cfg_active); end
        send(hdr(1, 1));
        checks++; if (cfg_active !== 1'b0) begin errors++; $display("FAIL desync_hdr_cfg: got %0b want 0", cfg_active); end
        for (int k = 0; k < NR; k++) send(32'h700 + k);
        idle(1);
        checks++; if (FrameStrobe !== '0) begin errors++; $display("FAIL desync_strobe: got %0h want 0", FrameStrobe); end
        checks++; if (frame_count !== 16'd3) begin errors++; $display("FAIL desync_count: got %0d want 3", frame_count); end
        checks++; if (FrameData[0 +: W] !== 32'h300) begin errors++; $display("FAIL desync_row0: got %0h want 300", FrameData[0 +: W]); end
    endtask

    task automatic test_reset_mid_frame();
        send(32'hFAB0_FAB1);
        send(hdr(3, 2));
        for (int k = 0; k < 8; k++) send(32'h500 + k);
        #2;
        RST = 1'b1;
        #1;
        checks++; if (FrameStrobe !== '0) begin errors++; $display("FAIL midrst_strobe: got %0h want 0", FrameStrobe); end
        checks++; if (FrameData !== '0) begin errors++; $display("FAIL midrst_data: got %0h want 0", FrameData); end
        checks++; if (cfg_active !== 1'b0) begin errors++; $display("FAIL midrst_cfg: got %0b want 0", cfg_active); end
        checks++; if (frame_count !== 16'd0) begin errors++; $display("FAIL midrst_count: got %0d want 0", frame_count); end
        checks++; if (addr_err !== 1'b0) begin errors++; $display("FAIL midrst_addr_err: got %0b want 0", addr_err); end
        @(negedge CLK);
        RST = 1'b0;
        @(posedge CLK); #1;
        for (int k = 0; k < 8; k++) send(32'h600 + k);
        checks++; if (cfg_active !== 1'b0) begin errors++; $display("FAIL midrst_idle: got %0b want 0", cfg_active); end
        send(32'hFAB0_FAB1);
        send(hdr(4, 0));
        for (int k = 0; k < NR; k++) send(32'h400 + k);
        exp_s = '0; exp_s[4*MF+0] = 1'b1;
        checks++; if (FrameStrobe !== exp_s) begin errors++; $display("FAIL resync_strobe: got %0h want %0h", FrameStrobe, exp_s); end
        for (int r = 0; r < NR; r++) begin
            checks++;
            if (FrameData[r*W +: W] !== 32'h400 + r) begin
                errors++; $display("FAIL resync_row %0d: got %0h want %0h", r, FrameData[r*W +: W], 32'h400 + r);
            end
        end
        idle(1);
        checks++; if (frame_count !== 16'd1) begin errors++; $display("FAIL resync_count: got %0d want 1", frame_count); end
    endtask

    initial begin
        test_reset();
        test_garbage_then_sync();
        test_basic_frame();
        test_addr_err();
        test_gaps();
        test_desync();
        test_reset_mid_frame();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
